// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the external asynchronous SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StEnd
  } state_e;

  // Per-bit drive enable for the two byte lanes.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable down-counter timing the ACCESS phase; done_o is high while the count is zero.
module sram_ctrl_timer
  import sram_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  en_i,
  output logic                  done_o
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Fabric-side controller turning a valid/ready request stream into timed async SRAM cycles.
// Optional byte-lane strobes (req_be, sram_ub_n, sram_lb_n) enabled by SRAM_CTRL_BYTE_LANE_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
`ifdef SRAM_CTRL_BYTE_LANE_EN
  input  logic [1:0]        req_be,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
`endif
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [15:0]       io_d,
  output logic [15:0]       io_e,
  input  logic [15:0]       io_y,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [WAIT_CNT_W-1:0] LoadVal = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   io_d_q, io_d_d;
  logic [DATA_W-1:0]   io_e_q, io_e_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic [1:0]          be;
  logic                timer_load;
  logic                timer_done;

`ifdef SRAM_CTRL_BYTE_LANE_EN
  assign be = req_be;
`else
  assign be = 2'b11;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    we_d        = we_q;
    sram_addr_d = sram_addr_q;
    io_d_d      = io_d_q;
    io_e_d      = io_e_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    timer_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = StSetup;
          req_ready_d = 1'b0;
          we_d        = req_we;
          sram_addr_d = req_addr;
          ce_n_d      = 1'b0;
          ub_n_d      = ~be[1];
          lb_n_d      = ~be[0];
          // Reads leave the bus undriven from SETUP on so the SRAM can turn it around.
          io_d_d      = req_we ? req_wdata : '0;
          io_e_d      = req_we ? lane_mask(be) : '0;
        end
      end
      StSetup: begin
        state_d    = StAccess;
        timer_load = 1'b1;
        if (we_q) begin
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      StAccess: begin
        if (timer_done) begin
          state_d = StEnd;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = io_y;
          end
        end
      end
      StEnd: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
        io_d_d      = '0;
        io_e_d      = '0;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      we_q        <= 1'b0;
      sram_addr_q <= '0;
      io_d_q      <= '0;
      io_e_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      we_q        <= we_d;
      sram_addr_q <= sram_addr_d;
      io_d_q      <= io_d_d;
      io_e_q      <= io_e_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
    end
  end

  sram_ctrl_timer u_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_i     (timer_load),
    .load_val_i (LoadVal),
    .en_i       (state_q == StAccess),
    .done_o     (timer_done)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign io_d      = io_d_q;
  assign io_e      = io_e_q;
  assign sram_addr = sram_addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

`ifdef SRAM_CTRL_BYTE_LANE_EN
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
`else
  logic unused_lanes;
  assign unused_lanes = ub_n_q ^ lb_n_q;
`endif

endmodule
